exu_div_ctrl_q: RTL and testbench

- Parametrised divide control unit in the EXU, placed between dispatch and the iterative divider; drives writeback requests to the WBU.
- Holds the tag of one in-flight divide and completes divide-by-zero operations locally, without starting the divider.
- Buffers completed results in a RES_DEPTH-entry FIFO, so the next divide can issue while earlier results wait for wb_ready_i.
- Adds flush/kill of the in-flight operation.

---
 rtl/exu_div_ctrl_q.sv | 158 +++++++++++++++
 tb/tb_exu_div_ctrl_q.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_div_ctrl_q.sv
// Divide control between dispatch and the iterative divider: tracks one in-flight divide,
// completes divide-by-zero locally and queues results in a small FIFO for writeback.
module exu_div_ctrl_q #(
   parameter int DATA_W    = 32,
   parameter int RADDR_W   = 5,
   parameter int CID_W     = 3,
   parameter int RES_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_div_i,
   input  logic [3:0]         div_op_i,
   input  logic [DATA_W-1:0]  reg1_rdata_i,
   input  logic [DATA_W-1:0]  reg2_rdata_i,
   input  logic [RADDR_W-1:0] reg_waddr_i,
   input  logic               reg_we_i,
   input  logic [CID_W-1:0]   commit_id_i,
   input  logic               int_assert_i,
   input  logic               flush_i,
   output logic               div_start_o,
   output logic [DATA_W-1:0]  div_dividend_o,
   output logic [DATA_W-1:0]  div_divisor_o,
   output logic [3:0]         div_op_o,
   output logic               div_kill_o,
   input  logic [DATA_W-1:0]  div_result_i,
   input  logic               div_busy_i,
   input  logic               div_valid_i,
   output logic               div_stall_o,
   output logic               idle_o,
   input  logic               wb_ready_i,
   output logic               reg_we_o,
   output logic [DATA_W-1:0]  reg_wdata_o,
   output logic [RADDR_W-1:0] reg_waddr_o,
   output logic [CID_W-1:0]   commit_id_o
);

   localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
   localparam int CNT_W = $clog2(RES_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RES_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RES_DEPTH - 1);

   typedef struct packed {
      logic [RADDR_W-1:0] waddr;
      logic               we;
      logic [CID_W-1:0]   cid;
   } tag_t;

   typedef struct packed {
      logic [DATA_W-1:0] res;
      tag_t              tag;
   } entry_t;

   entry_t           r_mem [RES_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_inflight;
   tag_t             r_tag;

   logic              w_req;
   logic              w_space;
   logic              w_dz;
   logic              w_accept;
   logic              w_issue;
   logic              w_bypass;
   logic              w_complete;
   logic              w_kill;
   logic              w_push;
   logic              w_pop;
   logic              w_head_v;
   tag_t              w_req_tag;
   logic [DATA_W-1:0] w_bypass_res;
   entry_t            w_push_entry;
   entry_t            w_head;

   assign w_req      = req_div_i & ~int_assert_i & ~flush_i;
   assign w_space    = (r_count < DEPTH_C);
   assign w_dz       = (reg2_rdata_i == '0);
   assign w_accept   = w_req & ~r_inflight & ~div_busy_i & w_space;
   assign w_issue    = w_accept & ~w_dz;
   assign w_bypass   = w_accept & w_dz;
   assign w_complete = div_valid_i & r_inflight & ~flush_i;
   assign w_kill     = flush_i & r_inflight;
   assign w_push     = w_bypass | w_complete;
   assign w_head     = r_mem[r_rd_ptr];
   assign w_head_v   = (r_count != '0);
   assign w_pop      = w_head_v & (wb_ready_i | ~w_head.tag.we);

   assign w_req_tag = '{waddr: reg_waddr_i, we: reg_we_i, cid: commit_id_i};

   // Divide by zero yields all-ones for div/divu and the dividend for rem/remu.
   assign w_bypass_res = (div_op_i[3] | div_op_i[2]) ? reg1_rdata_i : '1;

   // Bypass and completion never coincide: accept requires no divide in flight.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_push_entry = '{res: w_bypass_res, tag: w_req_tag};
      if (w_complete) begin
         w_push_entry = '{res: div_result_i, tag: r_tag};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state is updated only with non-blocking assignments.
         r_inflight <= 1'b0;
         r_tag      <= '0;
      end else begin
         if (w_issue) begin
            r_inflight <= 1'b1;
            r_tag      <= w_req_tag;
         end else if (w_complete | w_kill) begin
            r_inflight <= 1'b0;
         end
      end
   end

   // NOTE: the result storage is reset too; it is tiny, and that keeps every register at a known 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RES_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= w_push_entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   assign div_start_o    = w_issue;
   assign div_dividend_o = reg1_rdata_i;
   assign div_divisor_o  = reg2_rdata_i;
   assign div_op_o       = div_op_i;
   assign div_kill_o     = w_kill;
   assign div_stall_o    = req_div_i & ~int_assert_i & ~w_accept;
   assign idle_o         = ~r_inflight & ~w_head_v;

   assign reg_we_o    = w_head_v & w_head.tag.we;
   assign reg_wdata_o = w_head_v ? w_head.res : '0;
   assign reg_waddr_o = w_head_v ? w_head.tag.waddr : '0;
   assign commit_id_o = w_head_v ? w_head.tag.cid : '0;

endmodule

// File: tb/tb_exu_div_ctrl_q.sv
// Directed bench for exu_div_ctrl_q: the bench plays the divider, expected writebacks are
// queued when stimulus is driven and compared whenever the DUT hands a result to the WBU.
module tb_exu_div_ctrl_q;

   localparam int DATA_W    = 32;
   localparam int RADDR_W   = 5;
   localparam int CID_W     = 3;
   localparam int RES_DEPTH = 2;

   localparam logic [3:0] OP_DIV  = 4'b0001;
   localparam logic [3:0] OP_DIVU = 4'b0010;
   localparam logic [3:0] OP_REM  = 4'b0100;
   localparam logic [3:0] OP_REMU = 4'b1000;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               req_div_i = 1'b0;
   logic [3:0]         div_op_i = '0;
   logic [DATA_W-1:0]  reg1_rdata_i = '0;
   logic [DATA_W-1:0]  reg2_rdata_i = '0;
   logic [RADDR_W-1:0] reg_waddr_i = '0;
   logic               reg_we_i = 1'b0;
   logic [CID_W-1:0]   commit_id_i = '0;
   logic               int_assert_i = 1'b0;
   logic               flush_i = 1'b0;
   logic [DATA_W-1:0]  div_result_i = '0;
   logic               div_busy_i = 1'b0;
   logic               div_valid_i = 1'b0;
   logic               wb_ready_i = 1'b0;

   logic               div_start_o;
   logic [DATA_W-1:0]  div_dividend_o;
   logic [DATA_W-1:0]  div_divisor_o;
   logic [3:0]         div_op_o;
   logic               div_kill_o;
   logic               div_stall_o;
   logic               idle_o;
   logic               reg_we_o;
   logic [DATA_W-1:0]  reg_wdata_o;
   logic [RADDR_W-1:0] reg_waddr_o;
   logic [CID_W-1:0]   commit_id_o;

   exu_div_ctrl_q #(
      .DATA_W(DATA_W), .RADDR_W(RADDR_W), .CID_W(CID_W), .RES_DEPTH(RES_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_div_i(req_div_i), .div_op_i(div_op_i),
      .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
      .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .commit_id_i(commit_id_i),
      .int_assert_i(int_assert_i), .flush_i(flush_i),
      .div_start_o(div_start_o), .div_dividend_o(div_dividend_o),
      .div_divisor_o(div_divisor_o), .div_op_o(div_op_o), .div_kill_o(div_kill_o),
      .div_result_i(div_result_i), .div_busy_i(div_busy_i), .div_valid_i(div_valid_i),
      .div_stall_o(div_stall_o), .idle_o(idle_o), .wb_ready_i(wb_ready_i),
      .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o), .reg_waddr_o(reg_waddr_o),
      .commit_id_o(commit_id_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic [RADDR_W-1:0] waddr;
      logic [CID_W-1:0]   cid;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [3:0] op, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b, input logic [RADDR_W-1:0] wa,
                            input logic we, input logic [CID_W-1:0] cid);
      req_div_i    = 1'b1;
      div_op_i     = op;
      reg1_rdata_i = a;
      reg2_rdata_i = b;
      reg_waddr_i  = wa;
      reg_we_i     = we;
      commit_id_i  = cid;
   endtask

   task automatic expect_wb(input logic [DATA_W-1:0] d, input logic [RADDR_W-1:0] wa,
                            input logic [CID_W-1:0] cid);
      exp_t e;
      e.data  = d;
      e.waddr = wa;
      e.cid   = cid;
      sb_q.push_back(e);
   endtask

   // Scoreboard: a result is consumed whenever the WBU sees a valid write and is ready.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && reg_we_o && wb_ready_i) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_wb", 64'(reg_we_o), 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("sb_wdata", 64'(reg_wdata_o), 64'(e.data));
            check("sb_waddr", 64'(reg_waddr_o), 64'(e.waddr));
            check("sb_cid",   64'(commit_id_o), 64'(e.cid));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_idle",  64'(idle_o),      64'd1);
      check("rst_we",    64'(reg_we_o),    64'd0);
      check("rst_start", 64'(div_start_o), 64'd0);
      check("rst_stall", 64'(div_stall_o), 64'd0);
      check("rst_kill",  64'(div_kill_o),  64'd0);
      check("rst_wdata", 64'(reg_wdata_o), 64'd0);
      rst_n = 1'b1;
      tick();

      // Basic divide 100/7
      wb_ready_i = 1'b1;
      drive_req(OP_DIV, 32'd100, 32'd7, 5'd5, 1'b1, 3'd2);
      #1;
      check("basic_start",    64'(div_start_o),    64'd1);
      check("basic_stall",    64'(div_stall_o),    64'd0);
      check("basic_dividend", 64'(div_dividend_o), 64'd100);
      check("basic_divisor",  64'(div_divisor_o),  64'd7);
      check("basic_op",       64'(div_op_o),       64'(OP_DIV));
      tick();
      req_div_i  = 1'b0;
      div_busy_i = 1'b1;
      #1;
      check("basic_busy_idle", 64'(idle_o), 64'd0);
      tick();
      tick();
      div_busy_i   = 1'b0;
      div_valid_i  = 1'b1;
      div_result_i = 32'd100 / 32'd7;
      expect_wb(32'd14, 5'd5, 3'd2);
      tick();
      div_valid_i = 1'b0;
      #1;
      check("basic_wb_we", 64'(reg_we_o), 64'd1);
      tick();
      check("basic_idle_after", 64'(idle_o), 64'd1);

      // Divide-by-zero bypass: divu then remu back-to-back
      drive_req(OP_DIVU, 32'h1234, 32'd0, 5'd7, 1'b1, 3'd3);
      expect_wb(32'hFFFF_FFFF, 5'd7, 3'd3);
      #1;
      check("dz_divu_no_start", 64'(div_start_o), 64'd0);
      check("dz_divu_stall",    64'(div_stall_o), 64'd0);
      tick();
      drive_req(OP_REMU, 32'h1234, 32'd0, 5'd8, 1'b1, 3'd4);
      expect_wb(32'h1234, 5'd8, 3'd4);
      #1;
      check("dz_divu_visible",   64'(reg_wdata_o), 64'hFFFF_FFFF);
      check("dz_remu_no_start",  64'(div_start_o), 64'd0);
      tick();
      req_div_i = 1'b0;
      tick();
      tick();
      check("dz_idle", 64'(idle_o), 64'd1);

      // Backpressure: fill the FIFO, stall a third divide, then drain
      wb_ready_i = 1'b0;
      drive_req(OP_DIV, 32'd50, 32'd5, 5'd1, 1'b1, 3'd1);
      tick();
      req_div_i    = 1'b0;
      div_valid_i  = 1'b1;
      div_result_i = 32'd10;
      expect_wb(32'd10, 5'd1, 3'd1);
      tick();
      div_valid_i = 1'b0;
      drive_req(OP_DIVU, 32'd81, 32'd9, 5'd2, 1'b1, 3'd5);
      #1;
      check("bp_second_start", 64'(div_start_o), 64'd1);
      tick();
      req_div_i    = 1'b0;
      div_valid_i  = 1'b1;
      div_result_i = 32'd9;
      expect_wb(32'd9, 5'd2, 3'd5);
      tick();
      div_valid_i = 1'b0;
      #1;
      check("bp_full_head", 64'(reg_wdata_o), 64'd10);
      drive_req(OP_REM, 32'd17, 32'd5, 5'd3, 1'b1, 3'd6);
      #1;
      check("bp_full_stall",    64'(div_stall_o), 64'd1);
      check("bp_full_no_start", 64'(div_start_o), 64'd0);
      tick();
      wb_ready_i = 1'b1;
      #1;
      check("bp_pop_cycle_stall",    64'(div_stall_o), 64'd1);
      check("bp_pop_cycle_no_start", 64'(div_start_o), 64'd0);
      tick();
      check("bp_third_start", 64'(div_start_o), 64'd1);
      check("bp_third_stall", 64'(div_stall_o), 64'd0);
      tick();
      req_div_i    = 1'b0;
      div_valid_i  = 1'b1;
      div_result_i = 32'd17 % 32'd5;
      expect_wb(32'd2, 5'd3, 3'd6);
      tick();
      div_valid_i = 1'b0;
      tick();
      tick();
      check("bp_idle", 64'(idle_o), 64'd1);

      // Flush: an older queued entry survives, the killed result is dropped
      wb_ready_i = 1'b0;
      drive_req(OP_DIV, 32'd5, 32'd0, 5'd9, 1'b1, 3'd7);
      expect_wb(32'hFFFF_FFFF, 5'd9, 3'd7);
      tick();
      drive_req(OP_DIV, 32'd200, 32'd10, 5'd10, 1'b1, 3'd0);
      #1;
      check("fl_start", 64'(div_start_o), 64'd1);
      tick();
      req_div_i  = 1'b0;
      div_busy_i = 1'b1;
      tick();
      flush_i = 1'b1;
      #1;
      check("fl_kill", 64'(div_kill_o), 64'd1);
      tick();
      flush_i    = 1'b0;
      div_busy_i = 1'b0;
      #1;
      check("fl_kill_pulse", 64'(div_kill_o), 64'd0);
      div_valid_i  = 1'b1;
      div_result_i = 32'hDEAD;
      tick();
      div_valid_i = 1'b0;
      #1;
      check("fl_head_data",  64'(reg_wdata_o), 64'hFFFF_FFFF);
      check("fl_head_waddr", 64'(reg_waddr_o), 64'd9);
      wb_ready_i = 1'b1;
      tick();
      tick();
      check("fl_idle",   64'(idle_o),   64'd1);
      check("fl_no_dead", 64'(reg_we_o), 64'd0);
      drive_req(OP_DIV, 32'd8, 32'd2, 5'd4, 1'b1, 3'd1);
      flush_i = 1'b1;
      #1;
      check("fl_idle_kill",  64'(div_kill_o),  64'd0);
      check("fl_idle_start", 64'(div_start_o), 64'd0);
      check("fl_idle_stall", 64'(div_stall_o), 64'd1);
      tick();
      flush_i   = 1'b0;
      req_div_i = 1'b0;
      #1;
      check("fl_idle_after", 64'(idle_o), 64'd1);

      // Same-cycle div_valid_i and flush_i: nothing is pushed
      drive_req(OP_DIV, 32'd9, 32'd3, 5'd11, 1'b1, 3'd1);
      tick();
      req_div_i    = 1'b0;
      div_valid_i  = 1'b1;
      div_result_i = 32'd3;
      flush_i      = 1'b1;
      #1;
      check("sim_kill", 64'(div_kill_o), 64'd1);
      tick();
      div_valid_i = 1'b0;
      flush_i     = 1'b0;
      #1;
      check("sim_idle",  64'(idle_o),   64'd1);
      check("sim_no_wb", 64'(reg_we_o), 64'd0);

      // Pop and completion push in the same cycle
      wb_ready_i = 1'b0;
      drive_req(OP_DIVU, 32'd1, 32'd0, 5'd12, 1'b1, 3'd2);
      expect_wb(32'hFFFF_FFFF, 5'd12, 3'd2);
      tick();
      drive_req(OP_DIV, 32'd40, 32'd4, 5'd13, 1'b1, 3'd3);
      tick();
      req_div_i    = 1'b0;
      wb_ready_i   = 1'b1;
      div_valid_i  = 1'b1;
      div_result_i = 32'd10;
      expect_wb(32'd10, 5'd13, 3'd3);
      tick();
      div_valid_i = 1'b0;
      #1;
      check("pp_head_data", 64'(reg_wdata_o), 64'd10);
      tick();
      check("pp_idle", 64'(idle_o), 64'd1);

      // Full FIFO drains while a stray div_valid_i arrives with nothing in flight
      wb_ready_i = 1'b0;
      drive_req(OP_REM, 32'd77, 32'd0, 5'd14, 1'b1, 3'd4);
      expect_wb(32'd77, 5'd14, 3'd4);
      tick();
      drive_req(OP_REMU, 32'hABCD, 32'd0, 5'd15, 1'b1, 3'd5);
      expect_wb(32'hABCD, 5'd15, 3'd5);
      tick();
      drive_req(OP_DIV, 32'd6, 32'd0, 5'd16, 1'b1, 3'd6);
      #1;
      check("full_dz_stall", 64'(div_stall_o), 64'd1);
      req_div_i    = 1'b0;
      wb_ready_i   = 1'b1;
      div_valid_i  = 1'b1;
      div_result_i = 32'hBEEF;
      tick();
      div_valid_i = 1'b0;
      tick();
      check("full_idle", 64'(idle_o), 64'd1);

      // Interrupt blocks acceptance without stalling
      int_assert_i = 1'b1;
      drive_req(OP_DIV, 32'd10, 32'd0, 5'd17, 1'b1, 3'd7);
      #1;
      check("int_no_start", 64'(div_start_o), 64'd0);
      check("int_no_stall", 64'(div_stall_o), 64'd0);
      tick();
      req_div_i    = 1'b0;
      int_assert_i = 1'b0;
      #1;
      check("int_no_push", 64'(idle_o), 64'd1);

      // A no-write entry drains by itself while the WBU is not ready
      wb_ready_i = 1'b0;
      drive_req(OP_DIV, 32'd3, 32'd0, 5'd20, 1'b0, 3'd6);
      tick();
      req_div_i = 1'b0;
      #1;
      check("nowe_we",    64'(reg_we_o),    64'd0);
      check("nowe_busy",  64'(idle_o),      64'd0);
      check("nowe_waddr", 64'(reg_waddr_o), 64'd20);
      tick();
      check("nowe_drained", 64'(idle_o), 64'd1);

      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
